// File: rtl/hazard_scoreboard_unit.sv
// Hazard-detection and forwarding controller for the in-order MIPS pipeline.
// Tracks destination tags of in-flight instructions after ID; entry 0 is EXE.
module hazard_scoreboard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  localparam int unsigned SEL_W     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fwd_en,
  input  logic                    flush,
  input  logic                    id_valid,
  input  logic [REG_ADDR_W-1:0]   id_src1,
  input  logic [REG_ADDR_W-1:0]   id_src2,
  input  logic                    id_src1_used,
  input  logic                    id_src2_used,
  input  logic [REG_ADDR_W-1:0]   id_dest,
  input  logic                    id_wb_en,
  input  logic                    id_mem_r_en,
  input  logic [DATA_W-1:0]       rf_data1,
  input  logic [DATA_W-1:0]       rf_data2,
  input  logic [DEPTH*DATA_W-1:0] fwd_data,
  output logic                    stall,
  output logic                    fwd_hit1,
  output logic                    fwd_hit2,
  output logic [SEL_W-1:0]        fwd_sel1,
  output logic [SEL_W-1:0]        fwd_sel2,
  output logic [DATA_W-1:0]       op1_out,
  output logic [DATA_W-1:0]       op2_out,
  output logic [15:0]             stall_cycles
);

  logic [DEPTH-1:0]                 valid_q;
  logic [DEPTH-1:0]                 wb_en_q;
  logic [DEPTH-1:0]                 mem_r_en_q;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] dest_q;
  logic [REG_ADDR_W-1:0]            src1_q;
  logic [REG_ADDR_W-1:0]            src2_q;
  logic                             src1_used_q;
  logic                             src2_used_q;
  logic                             mode_q;
  logic [15:0]                      stall_cycles_q;

  // Slice 0 would be the EXE instruction's own result, which never forwards.
  logic [DATA_W-1:0] unused_fwd0;
  assign unused_fwd0 = fwd_data[DATA_W-1:0];

  // ID operands against entries that can still stall; EXE operands against producers.
  logic [DEPTH-2:0] id_m1, id_m2;
  logic [DEPTH-1:1] ex_m1, ex_m2;

  always_comb begin
    id_m1 = '0;
    id_m2 = '0;
    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
      id_m1[k] = valid_q[k] && wb_en_q[k] && (dest_q[k] != '0) && (dest_q[k] == id_src1) &&
                 id_src1_used;
      id_m2[k] = valid_q[k] && wb_en_q[k] && (dest_q[k] != '0) && (dest_q[k] == id_src2) &&
                 id_src2_used;
    end
  end

  always_comb begin
    ex_m1 = '0;
    ex_m2 = '0;
    for (int k = 1; k < int'(DEPTH); k++) begin
      ex_m1[k] = valid_q[k] && wb_en_q[k] && (dest_q[k] != '0) && (dest_q[k] == src1_q) &&
                 src1_used_q;
      ex_m2[k] = valid_q[k] && wb_en_q[k] && (dest_q[k] != '0) && (dest_q[k] == src2_q) &&
                 src2_used_q;
    end
  end

  always_comb begin
    stall = 1'b0;
    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
      if (fwd_en) begin
        if ((id_m1[k] || id_m2[k]) && mem_r_en_q[k] && (k + 1 < int'(LOAD_STAGE))) begin
          stall = 1'b1;
        end
      end else if (id_m1[k] || id_m2[k]) begin
        stall = 1'b1;
      end
    end
    if (flush || !id_valid) begin
      stall = 1'b0;
    end
  end

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    fwd_hit1 = 1'b0;
    fwd_hit2 = 1'b0;
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    op1_out  = rf_data1;
    op2_out  = rf_data2;
    for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
      if (valid_q[0] && mode_q && ex_m1[k] && (!mem_r_en_q[k] || k >= int'(LOAD_STAGE))) begin
        fwd_hit1 = 1'b1;
        fwd_sel1 = SEL_W'(k);
        op1_out  = fwd_data[k*DATA_W +: DATA_W];
      end
      if (valid_q[0] && mode_q && ex_m2[k] && (!mem_r_en_q[k] || k >= int'(LOAD_STAGE))) begin
        fwd_hit2 = 1'b1;
        fwd_sel2 = SEL_W'(k);
        op2_out  = fwd_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      wb_en_q        <= '0;
      mem_r_en_q     <= '0;
      dest_q         <= '0;
      src1_q         <= '0;
      src2_q         <= '0;
      src1_used_q    <= 1'b0;
      src2_used_q    <= 1'b0;
      mode_q         <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        valid_q[k]    <= valid_q[k-1];
        wb_en_q[k]    <= wb_en_q[k-1];
        mem_r_en_q[k] <= mem_r_en_q[k-1];
        dest_q[k]     <= dest_q[k-1];
      end
      valid_q[0]    <= id_valid && !stall && !flush;
      wb_en_q[0]    <= id_wb_en;
      mem_r_en_q[0] <= id_mem_r_en;
      dest_q[0]     <= id_dest;
      src1_q        <= id_src1;
      src2_q        <= id_src2;
      src1_used_q   <= id_src1_used;
      src2_used_q   <= id_src2_used;
      mode_q        <= fwd_en;
      if (stall && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit; EXE operand expectations go through a
// scoreboard queue pushed at issue and popped when the instruction reaches EXE.
module tb_hazard_scoreboard_unit;

  localparam logic [31:0] Rf1 = 32'h1111_1111;
  localparam logic [31:0] Rf2 = 32'h2222_2222;
  localparam logic [31:0] Sl0 = 32'hDEAD_BEEF;
  localparam logic [31:0] Sl1 = 32'h0000_00AA;
  localparam logic [31:0] Sl2 = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst;
  logic        fwd_en;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_src1, id_src2, id_dest;
  logic        id_src1_used, id_src2_used, id_wb_en, id_mem_r_en;
  logic [31:0] rf_data1, rf_data2;
  logic [95:0] fwd_data;
  logic        stall, fwd_hit1, fwd_hit2;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [31:0] op1_out, op2_out;
  logic [15:0] stall_cycles;

  typedef struct packed {
    logic        h1;
    logic [1:0]  s1;
    logic [31:0] o1;
    logic        h2;
    logic [1:0]  s2;
    logic [31:0] o2;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  hazard_scoreboard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .fwd_en       (fwd_en),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_r_en  (id_mem_r_en),
    .rf_data1     (rf_data1),
    .rf_data2     (rf_data2),
    .fwd_data     (fwd_data),
    .stall        (stall),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_sel1     (fwd_sel1),
    .fwd_sel2     (fwd_sel2),
    .op1_out      (op1_out),
    .op2_out      (op2_out),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_src1      = '0;
    id_src2      = '0;
    id_src1_used = 1'b0;
    id_src2_used = 1'b0;
    id_dest      = '0;
    id_wb_en     = 1'b0;
    id_mem_r_en  = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic issue(input logic [4:0] dest, input logic wb, input logic mr,
                       input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2);
    id_valid     = 1'b1;
    id_dest      = dest;
    id_wb_en     = wb;
    id_mem_r_en  = mr;
    id_src1      = s1;
    id_src1_used = u1;
    id_src2      = s2;
    id_src2_used = u2;
  endtask

  task automatic push(input logic h1, input logic [1:0] s1, input logic [31:0] o1,
                      input logic h2, input logic [1:0] s2, input logic [31:0] o2);
    exp_t e;
    e.h1 = h1; e.s1 = s1; e.o1 = o1;
    e.h2 = h2; e.s2 = s2; e.o2 = o2;
    sb.push_back(e);
  endtask

  task automatic check_exe(input string tag);
    exp_t e;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s: scoreboard empty, got no entry want one", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".hit1"}, {31'd0, fwd_hit1}, {31'd0, e.h1});
      chk({tag, ".sel1"}, {30'd0, fwd_sel1}, {30'd0, e.s1});
      chk({tag, ".op1"}, op1_out, e.o1);
      chk({tag, ".hit2"}, {31'd0, fwd_hit2}, {31'd0, e.h2});
      chk({tag, ".sel2"}, {30'd0, fwd_sel2}, {30'd0, e.s2});
      chk({tag, ".op2"}, op2_out, e.o2);
    end
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    rst      = 1'b1;
    fwd_en   = 1'b1;
    rf_data1 = Rf1;
    rf_data2 = Rf2;
    fwd_data = {Sl2, Sl1, Sl0};
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk("reset.cycles", {16'd0, stall_cycles}, 32'd0);
    push(1'b0, 2'd0, Rf1, 1'b0, 2'd0, Rf2);
    check_exe("reset");

    // ALU forward from entry 1; mode change after issue must not affect it.
    fwd_en = 1'b1;
    issue(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 chk("alu.prod_stall", {31'd0, stall}, 32'd0);
    tick();
    issue(5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
    #1 chk("alu.cons_stall", {31'd0, stall}, 32'd0);
    push(1'b1, 2'd1, Sl1, 1'b0, 2'd0, Rf2);
    tick();
    idle();
    fwd_en = 1'b0;
    #1 check_exe("alu");
    chk("alu.cycles", {16'd0, stall_cycles}, 32'd0);
    fwd_en = 1'b1;
    drain();

    // Load-use: one bubble, then forward from entry 2.
    issue(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    #1 chk("ld.stall0", {31'd0, stall}, 32'd1);
    tick();
    #1 chk("ld.stall1", {31'd0, stall}, 32'd0);
    chk("ld.cycles", {16'd0, stall_cycles}, 32'd1);
    push(1'b0, 2'd0, Rf1, 1'b1, 2'd2, Sl2);
    tick();
    idle();
    #1 check_exe("ld");
    drain();

    // Stall-only mode: two stall cycles, no forwarding.
    fwd_en = 1'b0;
    issue(5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
    #1 chk("so.stall0", {31'd0, stall}, 32'd1);
    tick();
    #1 chk("so.stall1", {31'd0, stall}, 32'd1);
    tick();
    #1 chk("so.stall2", {31'd0, stall}, 32'd0);
    chk("so.cycles", {16'd0, stall_cycles}, 32'd3);
    push(1'b0, 2'd0, Rf1, 1'b0, 2'd0, Rf2);
    tick();
    idle();
    #1 check_exe("so");
    drain();

    // r0 never creates a dependency, even in stall-only mode.
    fwd_en = 1'b0;
    issue(5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    #1 chk("r0.stall_so", {31'd0, stall}, 32'd0);
    fwd_en = 1'b1;
    #1 chk("r0.stall_fw", {31'd0, stall}, 32'd0);
    push(1'b0, 2'd0, Rf1, 1'b0, 2'd0, Rf2);
    tick();
    idle();
    #1 check_exe("r0");
    drain();

    // Two producers of r4: the youngest (entry 1) wins.
    issue(5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
    #1 chk("prio.stall", {31'd0, stall}, 32'd0);
    push(1'b1, 2'd1, Sl1, 1'b0, 2'd0, Rf2);
    tick();
    idle();
    #1 check_exe("prio");
    drain();

    // Flush kills a load-use consumer; it must not reach EXE.
    issue(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd5, 1'b1);
    flush = 1'b1;
    #1 chk("flush.stall", {31'd0, stall}, 32'd0);
    push(1'b0, 2'd0, Rf1, 1'b0, 2'd0, Rf2);
    tick();
    idle();
    #1 check_exe("flush");
    chk("flush.cycles", {16'd0, stall_cycles}, 32'd3);
    drain();

    // Reset during an active stall.
    issue(5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
    #1 chk("rst_mid.stall_pre", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("rst_mid.stall", {31'd0, stall}, 32'd0);
    chk("rst_mid.cycles", {16'd0, stall_cycles}, 32'd0);
    chk("rst_mid.hit1", {31'd0, fwd_hit1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
